// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, flag bit positions and op codes used by
// the arbiter and by instruction decode.
package alu_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int ALU_OPW   = 3;

   localparam int FLG_C = 3;
   localparam int FLG_V = 2;
   localparam int FLG_N = 1;
   localparam int FLG_Z = 0;

   typedef enum logic [ALU_OPW-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the core and the address/branch unit.
// Op select is {X,Y,Z}; subtraction reports cout=1 when no borrow occurred.
module alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             X,
   input  logic             Y,
   input  logic             Z,
   output logic [WIDTH-1:0] C,
   output logic             cout,
   output logic             Ov,
   output logic             Neg,
   output logic             Zero
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum  = '0;
      C    = '0;
      cout = 1'b0;
      Ov   = 1'b0;
      case ({X, Y, Z})
         OP_ADD: begin
            sum  = {1'b0, A} + {1'b0, B};
            C    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
            Ov   = (A[WIDTH-1] == B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
            C    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
            Ov   = (A[WIDTH-1] != B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: C = A & B;
         OP_OR:  C = A | B;
         OP_XOR: C = A ^ B;
         OP_NOT: C = ~A;
         OP_SHL: begin
            C    = {A[WIDTH-2:0], 1'b0};
            cout = A[WIDTH-1];
         end
         default: begin
            C    = {1'b0, A[WIDTH-1:1]};
            cout = A[0];
         end
      endcase
      Neg  = C[WIDTH-1];
      Zero = (C == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (req0) and the
// address/branch unit (req1), with registered responses and core status.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = ALU_OPW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   output logic [3:0]       rsp0_flags,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic [3:0]       rsp1_flags,
   output logic [3:0]       status
);

   logic             last_grant;
   logic             elig0, elig1;
   logic             grant0, grant1;
   logic             sel;
   logic [OPW-1:0]   mux_op;
   logic [WIDTH-1:0] mux_a, mux_b;
   logic [WIDTH-1:0] alu_c;
   logic             alu_cout, alu_ov, alu_neg, alu_zero;
   logic [3:0]       alu_flags;

   // A requester whose response is still held cannot be granted, which
   // leaves every slot to the other side instead of deadlocking.
   assign elig0  = req0_valid & (~rsp0_valid | rsp0_ready);
   assign elig1  = req1_valid & (~rsp1_valid | rsp1_ready);
   assign grant0 = elig0 & (~elig1 | last_grant);
   assign grant1 = elig1 & (~elig0 | ~last_grant);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // last_grant doubles as the held mux selection when nobody is granted.
   assign sel    = (grant0 | grant1) ? grant1 : last_grant;
   assign mux_op = sel ? req1_op : req0_op;
   assign mux_a  = sel ? req1_a  : req0_a;
   assign mux_b  = sel ? req1_b  : req0_b;

   alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
      .A    (mux_a),
      .B    (mux_b),
      .X    (mux_op[2]),
      .Y    (mux_op[1]),
      .Z    (mux_op[0]),
      .C    (alu_c),
      .cout (alu_cout),
      .Ov   (alu_ov),
      .Neg  (alu_neg),
      .Zero (alu_zero)
   );

   always_comb begin
      alu_flags        = '0;
      alu_flags[FLG_C] = alu_cout;
      alu_flags[FLG_V] = alu_ov;
      alu_flags[FLG_N] = alu_neg;
      alu_flags[FLG_Z] = alu_zero;
   end

   // A new accept takes priority over a drain so a continuously draining
   // consumer sees one result per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_flags <= '0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_flags <= '0;
         status     <= '0;
         last_grant <= 1'b1;
      end else begin
         if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_c;
            rsp0_flags <= alu_flags;
            status     <= alu_flags;
         end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_c;
            rsp1_flags <= alu_flags;
         end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end
         if (grant0) begin
            last_grant <= 1'b0;
         end else if (grant1) begin
            last_grant <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference arbiter/ALU model predicts
// grants, responses and status; held responses are checked for stability.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       rsp0_valid, rsp1_valid;
   logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [7:0] rsp0_data, rsp1_data;
   logic [3:0] rsp0_flags, rsp1_flags, status;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .rsp0_flags (rsp0_flags),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data),
      .rsp1_flags (rsp1_flags),
      .status     (status)
   );

   int vectors = 0;
   int miscompares = 0;
   int pushed = 0, popped = 0;
   int grant1_count = 0;

   logic [11:0] q0[$];
   logic [11:0] q1[$];
   logic        m_rv0 = 1'b0, m_rv1 = 1'b0, m_last = 1'b1;
   logic [3:0]  m_status = '0;
   logic        pend0 = 1'b0, pend1 = 1'b0;
   logic        seen0, seen1, prev1;
   logic [11:0] head;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference ALU written in integer arithmetic; returns {data, flags}.
   function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int ua = a, ub = b;
      int sa = $signed(a), sb = $signed(b);
      int r = 0, sr = 0;
      logic [7:0] d = '0;
      logic c = 1'b0, v = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; d = r[7:0]; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
         3'd1: begin r = ua - ub; d = r[7:0]; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
         3'd2: d = a & b;
         3'd3: d = a | b;
         3'd4: d = a ^ b;
         3'd5: d = ~a;
         3'd6: begin d = {a[6:0], 1'b0}; c = a[7]; end
         default: begin d = {1'b0, a[7:1]}; c = a[0]; end
      endcase
      return {d, c, v, d[7], (d == 8'd0)};
   endfunction

   // One clock of stimulus; an unaccepted request is held unchanged.
   task automatic applyStimulus(input logic v0, input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                                input logic v1, input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                                input logic r0, input logic r1);
      logic e0, e1, g0, g1;
      @(negedge clk);
      if (!pend0) begin
         req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      end
      if (!pend1) begin
         req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      end
      rsp0_ready = r0;
      rsp1_ready = r1;
      #1;
      e0 = req0_valid & (~m_rv0 | r0);
      e1 = req1_valid & (~m_rv1 | r1);
      g0 = e0 & (~e1 | m_last);
      g1 = e1 & (~e0 | ~m_last);
      seen0 = req0_ready;
      seen1 = req1_ready;
      checkOutput("rsp0_valid", rsp0_valid, m_rv0);
      checkOutput("rsp1_valid", rsp1_valid, m_rv1);
      checkOutput("status", status, m_status);
      checkOutput("req0_ready", req0_ready, g0);
      checkOutput("req1_ready", req1_ready, g1);
      if (m_rv0) begin
         checkOutput("rsp0 queued", (q0.size() != 0), 1);
         if (q0.size() != 0) begin
            head = r0 ? q0.pop_front() : q0[0];
            if (r0) popped++;
            checkOutput("rsp0_data", rsp0_data, head[11:4]);
            checkOutput("rsp0_flags", rsp0_flags, head[3:0]);
         end
      end
      if (m_rv1) begin
         checkOutput("rsp1 queued", (q1.size() != 0), 1);
         if (q1.size() != 0) begin
            head = r1 ? q1.pop_front() : q1[0];
            if (r1) popped++;
            checkOutput("rsp1_data", rsp1_data, head[11:4]);
            checkOutput("rsp1_flags", rsp1_flags, head[3:0]);
         end
      end
      if (g0) begin
         head = alu_model(req0_op, req0_a, req0_b);
         q0.push_back(head);
         m_status = head[3:0];
         pushed++;
      end
      if (g1) begin
         q1.push_back(alu_model(req1_op, req1_a, req1_b));
         pushed++;
         grant1_count++;
      end
      m_rv0 = g0 | (m_rv0 & ~r0);
      m_rv1 = g1 | (m_rv1 & ~r1);
      m_last = g1 ? 1'b1 : (g0 ? 1'b0 : m_last);
      pend0 = req0_valid & ~g0;
      pend1 = req1_valid & ~g1;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("reset rsp0_valid", rsp0_valid, 0);
      checkOutput("reset rsp1_valid", rsp1_valid, 0);
      checkOutput("reset rsp0_data", rsp0_data, 0);
      checkOutput("reset rsp1_data", rsp1_data, 0);
      checkOutput("reset rsp0_flags", rsp0_flags, 0);
      checkOutput("reset rsp1_flags", rsp1_flags, 0);
      checkOutput("reset status", status, 0);
      q0.delete();
      q1.delete();
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_last = 1'b1; m_status = '0;
      pend0 = 1'b0; pend1 = 1'b0;
      pushed = 0; popped = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      doReset();

      // Single requester, simple add and subtract, then signed overflow.
      applyStimulus(1, 3'd0, 8'd15, 8'd20, 0, 3'd0, 8'd0, 8'd0, 1, 1);
      checkOutput("t1 data", rsp0_data, 35);
      checkOutput("t1 flags", rsp0_flags, 4'b0000);
      checkOutput("t1 status", status, 4'b0000);
      applyStimulus(1, 3'd1, 8'd20, 8'd15, 0, 3'd0, 8'd0, 8'd0, 1, 1);
      checkOutput("t2 sub data", rsp0_data, 5);
      applyStimulus(1, 3'd0, 8'h9C, 8'hCE, 0, 3'd0, 8'd0, 8'd0, 1, 1);
      checkOutput("t2 ovf data", rsp0_data, 106);
      checkOutput("t2 ovf flags", rsp0_flags, 4'b1100);
      checkOutput("t2 ovf status", status, 4'b1100);

      // Both requesters every cycle with draining consumers: alternate grants.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 3'(i), 8'($urandom), 8'($urandom), 1, 3'(i + 3), 8'($urandom), 8'($urandom), 1, 1);
         checkOutput("t3 one accept", 32'(seen0) + 32'(seen1), 1);
         if (i > 0) checkOutput("t3 alternate", seen0, prev1);
         prev1 = seen1;
      end
      for (int i = 0; i < 2; i++)
         applyStimulus(0, 3'd0, 8'd0, 8'd0, 0, 3'd0, 8'd0, 8'd0, 1, 1);

      // req1 consumer stalls: one req1 accept, then req0 owns the ALU.
      grant1_count = 0;
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 3'd0, 8'(i * 7), 8'(i + 1), 1, 3'd1, 8'(100 + i), 8'(i), 1, 0);
      checkOutput("t4 req1 grants", grant1_count, 1);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 3'd0, 8'd0, 8'd0, 0, 3'd0, 8'd0, 8'd0, 1, 1);

      // Back-to-back req0 accepts while draining keep rsp0_valid high.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 3'd0, 8'(i * 11), 8'd3, 0, 3'd0, 8'd0, 8'd0, 1, 1);
         checkOutput("t5 rsp0 held high", rsp0_valid, 1);
      end
      applyStimulus(0, 3'd0, 8'd0, 8'd0, 0, 3'd0, 8'd0, 8'd0, 1, 1);
      checkOutput("t5 scoreboard balance", popped, pushed);

      // Random traffic with random back-pressure.
      for (int i = 0; i < 300; i++)
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
                       ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));

      // Build held responses, then reset mid-stream.
      applyStimulus(1, 3'd2, 8'hF0, 8'h3C, 1, 3'd4, 8'h55, 8'hAA, 0, 0);
      applyStimulus(1, 3'd3, 8'h0F, 8'h30, 1, 3'd6, 8'h81, 8'h00, 0, 0);
      doReset();
      applyStimulus(1, 3'd0, 8'd1, 8'd2, 1, 3'd0, 8'd3, 8'd4, 1, 1);
      checkOutput("t6 first grant req0", seen0, 1);
      checkOutput("t6 req1 waits", seen1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 3'd0, 8'd0, 8'd0, 0, 3'd0, 8'd0, 8'd0, 1, 1);
      checkOutput("final scoreboard balance", popped, pushed);
      checkOutput("final q0 empty", q0.size(), 0);
      checkOutput("final q1 empty", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
